// File: rtl/act_packer_pkg.sv
// act_packer_pkg: shared fixed-point defaults for the activation datapath.
package act_packer_pkg;
  localparam int def_width = 16;
  localparam int int_bits = 5;
  localparam int frac_bits = 10;
endpackage

// File: rtl/act_packer.sv
// act_packer: widens z/fi-lane activation/sigmoid-prime beats into z-lane packages.
module act_packer
  import act_packer_pkg::*;
#(
  parameter int fi = 4,
  parameter int z = 8,
  parameter int width = def_width
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [width*z/fi-1:0]   sigmoid_package,
  input  logic [width*z/fi-1:0]   sp_package,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [width*z-1:0]      a_package,
  output logic [width*z-1:0]      sp_out_package
);
  localparam int bw = width*z/fi;
  localparam int cw = $clog2(fi);
  logic [cw-1:0] cnt;
  logic [bw*(fi-1)-1:0] fill_a, fill_s;
  logic last, accept;
  assign last = cnt == cw'(fi-1);
  assign in_ready = !(last && out_valid && !out_ready);
  assign accept = in_valid && in_ready && !clear;
  // only beats 0..fi-2 are buffered; the final beat goes straight to the output register
  for (genvar k = 0; k < fi-1; k++) begin : g_slot
    logic [bw-1:0] a_q, s_q;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        a_q <= '0;
        s_q <= '0;
      end else if (accept && cnt == cw'(k)) begin
        a_q <= sigmoid_package;
        s_q <= sp_package;
      end
    assign fill_a[k*bw +: bw] = a_q;
    assign fill_s[k*bw +: bw] = s_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      out_valid <= 1'b0;
      a_package <= '0;
      sp_out_package <= '0;
    end else begin
      if (clear) cnt <= '0;
      else if (accept) cnt <= last ? '0 : cnt + cw'(1);
      if (accept && last) begin
        a_package <= {sigmoid_package, fill_a};
        sp_out_package <= {sp_package, fill_s};
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_act_packer.sv
// tb_act_packer: table-driven directed checks of act_packer with fi=4, z=8, width=16.
module tb_act_packer;
  localparam int fi = 4, z = 8, width = 16;
  typedef struct {
    logic clr, iv, ordy;
    int k, bb;
    logic er, ev, cd;
    int eb;
  } vec_t;
  logic clk = 0, reset = 0, clear = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [31:0] sigmoid_package = '0, sp_package = '0;
  logic [127:0] a_package, sp_out_package;
  int errors = 0, checks = 0;
  vec_t vecs[$];
  always #5 clk = ~clk;
  act_packer #(.fi(fi), .z(z), .width(width)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .sigmoid_package(sigmoid_package), .sp_package(sp_package), .out_valid(out_valid),
    .out_ready(out_ready), .a_package(a_package), .sp_out_package(sp_out_package)
  );
  function automatic logic [31:0] beat(int k, int b, logic [15:0] x);
    return {16'(b + 2*k + 2) ^ x, 16'(b + 2*k + 1) ^ x};
  endfunction
  function automatic logic [127:0] pkg(int b, logic [15:0] x);
    logic [127:0] p;
    for (int l = 0; l < 8; l++) p[l*16 +: 16] = 16'(b + l + 1) ^ x;
    return p;
  endfunction
  function automatic vec_t mk(logic clr, logic iv, logic ordy, int k, int bb,
                              logic er, logic ev, logic cd, int eb);
    vec_t v;
    v.clr = clr; v.iv = iv; v.ordy = ordy; v.k = k; v.bb = bb;
    v.er = er; v.ev = ev; v.cd = cd; v.eb = eb;
    return v;
  endfunction
  task automatic check(string name, int idx, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic step(vec_t v, int idx);
    @(negedge clk);
    clear = v.clr;
    in_valid = v.iv;
    out_ready = v.ordy;
    sigmoid_package = beat(v.k, v.bb, 16'h0000);
    sp_package = beat(v.k, v.bb, 16'h8000);
    #1 check("in_ready", idx, 128'(in_ready), 128'(v.er));
    @(posedge clk);
    #1 check("out_valid", idx, 128'(out_valid), 128'(v.ev));
    if (v.cd) begin
      check("a_package", idx, a_package, pkg(v.eb, 16'h0000));
      check("sp_out_package", idx, sp_out_package, pkg(v.eb, 16'h8000));
    end
  endtask
  initial begin
    #1 reset = 1;
    #2;
    check("rst_out_valid", 0, 128'(out_valid), 128'(0));
    check("rst_a", 0, a_package, 128'(0));
    check("rst_sp", 0, sp_out_package, 128'(0));
    check("rst_in_ready", 0, 128'(in_ready), 128'(1));
    @(negedge clk) reset = 0;
    // back-to-back packages, downstream always ready
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, 1, i % 4, i < 4 ? 0 : 8, 1, i % 4 == 3, i % 4 == 3, i < 4 ? 0 : 8));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0));
    // backpressure on the final beat while package 1 is held
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 0, i, 16, 1, i == 3, i == 3, 16));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, i, 24, 1, 1, 1, 16));
    vecs.push_back(mk(0, 1, 0, 3, 24, 0, 1, 1, 16));
    vecs.push_back(mk(0, 1, 0, 3, 24, 0, 1, 1, 16));
    vecs.push_back(mk(0, 1, 1, 3, 24, 1, 1, 1, 24));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 24));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0));
    // clear drops a partial package and the same-cycle beat
    vecs.push_back(mk(0, 1, 1, 0, 40, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 40, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 2, 40, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 1, i, 48, 1, i == 3, i == 3, 48));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 48));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0));
    foreach (vecs[i]) step(vecs[i], i);
    // asynchronous reset mid-package with a held output
    for (int i = 0; i < 4; i++) step(mk(0, 1, 0, i, 56, 1, i == 3, i == 3, 56), 100 + i);
    for (int i = 0; i < 3; i++) step(mk(0, 1, 0, i, 64, 1, 1, 1, 56), 104 + i);
    @(negedge clk) in_valid = 0;
    @(posedge clk);
    #3 reset = 1;
    #0.5;
    check("async_out_valid", 107, 128'(out_valid), 128'(0));
    check("async_a", 107, a_package, 128'(0));
    check("async_sp", 107, sp_out_package, 128'(0));
    check("async_in_ready", 107, 128'(in_ready), 128'(1));
    #0.5 reset = 0;
    for (int i = 0; i < 4; i++) step(mk(0, 1, 1, i, 72, 1, i == 3, i == 3, 72), 110 + i);
    step(mk(0, 0, 1, 0, 0, 1, 0, 0, 0), 114);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
